// File: rtl/downtimer_pkg.sv
// Shared definitions for the reloadable down-timer: FSM encoding and status byte layout.
package downtimer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_TC   = 2;
    localparam int STAT_MODE = 3;

    localparam int PSEL_W = 3;

endpackage

// File: rtl/downtimer_core.sv
// Down-counting timer core: FSM, counter, power-of-two prescaler and reload register.
//   state | meaning
//   IDLE  | not counting; cnt holds whatever it had when stopped
//   RUN   | counting down one step per prescaler tick
//   DONE  | one-shot expired (or zero start); cnt held at 0
module downtimer_core
    import downtimer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PSW   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_edge,
    input  logic              load,
    input  logic              stop,
    input  logic              mode,
    input  logic [PSEL_W-1:0] psel,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  cnt,
    output state_e            state,
    output logic              tc,
    output logic              mode_l
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    reload_q, reload_d;
    logic [PSW-1:0]      pre_q, pre_d;
    logic [PSEL_W-1:0]   psel_q, psel_d;
    logic                mode_q, mode_d;
    logic                tc_q, tc_d;
    logic [WIDTH-1:0]    eff_val;
    logic [PSW-1:0]      pre_mask;
    logic                tick;

    // A load in the start cycle bypasses the reload register.
    assign eff_val  = load ? din : reload_q;
    assign pre_mask = ~({PSW{1'b1}} << psel_q);
    assign tick     = (pre_q == pre_mask);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = load ? din : reload_q;
        pre_d    = pre_q;
        psel_d   = psel_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;
        if (start_edge && !stop) begin
            mode_d = mode;
            psel_d = psel;
            pre_d  = '0;
            if (eff_val == '0) begin
                state_d = ST_DONE;
                cnt_d   = '0;
                tc_d    = 1'b1;
            end else begin
                state_d = ST_RUN;
                cnt_d   = eff_val;
            end
        end else if (state_q == ST_RUN) begin
            if (stop) begin
                state_d = ST_IDLE;
            end else if (tick) begin
                pre_d = '0;
                if (cnt_q > CNT_ONE) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    tc_d = 1'b1;
                    if (mode_q) begin
                        cnt_d = reload_q;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end
                end
            end else begin
                pre_d = pre_q + PSW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            pre_q    <= '0;
            psel_q   <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            pre_q    <= pre_d;
            psel_q   <= psel_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
        end
    end

    assign cnt    = cnt_q;
    assign state  = state_q;
    assign tc     = tc_q;
    assign mode_l = mode_q;

endmodule

// File: rtl/tt_um_downtimer8_reload.sv
// TinyTapeout wrapper for the 8-bit reloadable down-timer: pin mapping, start-edge detect, output mux.
module tt_um_downtimer8_reload
    import downtimer_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic       start_q, start_d;
    logic       start_edge;
    logic [7:0] cnt;
    state_e     state;
    logic       tc;
    logic       mode_l;
    logic [7:0] status;
    logic       unused_ena;

    assign start_d    = ui_in[0];
    assign start_edge = ui_in[0] & ~start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start_d;
        end
    end

    downtimer_core #(
        .WIDTH (8),
        .PSW   (7)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_edge (start_edge),
        .load       (ui_in[1]),
        .stop       (ui_in[3]),
        .mode       (ui_in[4]),
        .psel       (ui_in[7:5]),
        .din        (uio_in),
        .cnt        (cnt),
        .state      (state),
        .tc         (tc),
        .mode_l     (mode_l)
    );

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = (state == ST_RUN);
        status[STAT_DONE] = (state == ST_DONE);
        status[STAT_TC]   = tc;
        status[STAT_MODE] = mode_l;
    end

    assign uo_out     = ui_in[2] ? cnt : status;
    assign uio_out    = 8'h00;
    assign uio_oe     = 8'h00;
    assign unused_ena = ena;

endmodule

// File: tb/tb_tt_um_downtimer8_reload.sv
// Self-checking bench for tt_um_downtimer8_reload: directed table, hand sequences, random vs model.
module tb_tt_um_downtimer8_reload;

    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
    logic       ena, clk, rst_n;

    int errors = 0;
    int checks = 0;

    tt_um_downtimer8_reload dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] ui;
        logic [7:0] uio;
        logic [7:0] exp_cnt;
        logic [7:0] exp_st;
    } vec_t;

    vec_t tbl[17];

    // behavioural model state
    int m_st, m_cnt, m_reload, m_n, m_el, m_p, m_mode, m_tc, m_sp;

    task automatic cyc(input logic [7:0] u, input logic [7:0] v);
        @(negedge clk);
        ui_in  = u;
        uio_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] ec, input logic [7:0] es);
        logic [7:0] saved;
        saved     = ui_in;
        ui_in[2]  = 1'b1;
        #1;
        checks++;
        if (uo_out !== ec) begin
            errors++;
            $display("FAIL %s count: got=%02h exp=%02h", nm, uo_out, ec);
        end
        ui_in[2] = 1'b0;
        #1;
        checks++;
        if (uo_out !== es) begin
            errors++;
            $display("FAIL %s status: got=%02h exp=%02h", nm, uo_out, es);
        end
        ui_in = saved;
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_reload = 0; m_n = 0; m_el = 0;
        m_p = 1; m_mode = 0; m_tc = 0; m_sp = 0;
    endtask

    // Timer described by elapsed cycles since start: value = N - elapsed / 2^psel.
    task automatic model_step(input logic [7:0] u, input logic [7:0] v);
        int eff;
        m_tc = 0;
        if (u[0] && (m_sp == 0) && !u[3]) begin
            eff    = u[1] ? int'(v) : m_reload;
            m_mode = int'(u[4]);
            m_p    = 1 << u[7:5];
            if (eff == 0) begin
                m_st = 2; m_cnt = 0; m_tc = 1;
            end else begin
                m_st = 1; m_n = eff; m_el = 0; m_cnt = eff;
            end
        end else if (m_st == 1 && u[3]) begin
            m_st = 0;
        end else if (m_st == 1) begin
            m_el++;
            if (m_el == m_n * m_p) begin
                m_tc = 1;
                if (m_mode != 0) begin
                    m_n = m_reload; m_el = 0; m_cnt = m_n;
                end else begin
                    m_st = 2; m_cnt = 0;
                end
            end else begin
                m_cnt = m_n - m_el / m_p;
            end
        end
        if (u[1]) m_reload = int'(v);
        m_sp = int'(u[0]);
    endtask

    function automatic logic [7:0] model_status();
        logic [7:0] s;
        s    = 8'h00;
        s[0] = (m_st == 1);
        s[1] = (m_st == 2);
        s[2] = (m_tc != 0);
        s[3] = (m_mode != 0);
        return s;
    endfunction

    initial begin
        logic [7:0] u, v;
        logic       cur_start;

        // ui bits: 0 start, 1 load, 2 sel, 3 stop, 4 mode, 7:5 psel
        tbl[0]  = '{8'h02, 8'h05, 8'h00, 8'h00};
        tbl[1]  = '{8'h01, 8'h00, 8'h05, 8'h01};
        tbl[2]  = '{8'h01, 8'h00, 8'h04, 8'h01};
        tbl[3]  = '{8'h00, 8'h00, 8'h03, 8'h01};
        tbl[4]  = '{8'h00, 8'h00, 8'h02, 8'h01};
        tbl[5]  = '{8'h00, 8'h00, 8'h01, 8'h01};
        tbl[6]  = '{8'h00, 8'h00, 8'h00, 8'h06};
        tbl[7]  = '{8'h00, 8'h00, 8'h00, 8'h02};
        tbl[8]  = '{8'h02, 8'h03, 8'h00, 8'h02};
        tbl[9]  = '{8'h11, 8'h00, 8'h03, 8'h09};
        tbl[10] = '{8'h10, 8'h00, 8'h02, 8'h09};
        tbl[11] = '{8'h10, 8'h00, 8'h01, 8'h09};
        tbl[12] = '{8'h10, 8'h00, 8'h03, 8'h0D};
        tbl[13] = '{8'h10, 8'h00, 8'h02, 8'h09};
        tbl[14] = '{8'h10, 8'h00, 8'h01, 8'h09};
        tbl[15] = '{8'h10, 8'h00, 8'h03, 8'h0D};
        tbl[16] = '{8'h18, 8'h00, 8'h03, 8'h08};

        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;
        rst_n  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_state", 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].ui, tbl[i].uio);
            chk($sformatf("table_row%0d", i), tbl[i].exp_cnt, tbl[i].exp_st);
        end

        // prescaler /4, one-shot, reload 2
        cyc(8'h02, 8'h02);
        cyc(8'h41, 8'h00);
        chk("psel2_start", 8'h02, 8'h01);
        for (int j = 1; j <= 9; j++) begin
            cyc(8'h40, 8'h00);
            if (j < 4)       chk($sformatf("psel2_j%0d", j), 8'h02, 8'h01);
            else if (j < 8)  chk($sformatf("psel2_j%0d", j), 8'h01, 8'h01);
            else if (j == 8) chk("psel2_tc", 8'h00, 8'h06);
            else             chk("psel2_done", 8'h00, 8'h02);
        end

        // stop at 0x0A, start ignored under stop, restart afterwards
        cyc(8'h02, 8'h10);
        cyc(8'h01, 8'h00);
        chk("stop_start", 8'h10, 8'h01);
        for (int j = 0; j < 6; j++) cyc(8'h00, 8'h00);
        chk("stop_pre", 8'h0A, 8'h01);
        cyc(8'h08, 8'h00);
        chk("stop_idle", 8'h0A, 8'h00);
        cyc(8'h09, 8'h00);
        chk("stop_start_ignored", 8'h0A, 8'h00);
        cyc(8'h00, 8'h00);
        chk("stop_released", 8'h0A, 8'h00);
        cyc(8'h01, 8'h00);
        chk("restart_after_stop", 8'h10, 8'h01);

        // load+start bypass, and reload register updated as well
        cyc(8'h00, 8'h00);
        cyc(8'h03, 8'h80);
        chk("bypass", 8'h80, 8'h01);
        cyc(8'h08, 8'h00);
        cyc(8'h00, 8'h00);
        cyc(8'h01, 8'h00);
        chk("bypass_reload", 8'h80, 8'h01);

        // zero reload goes straight to DONE
        cyc(8'h08, 8'h00);
        cyc(8'h02, 8'h00);
        cyc(8'h01, 8'h00);
        chk("zero_tc", 8'h00, 8'h06);
        cyc(8'h00, 8'h00);
        chk("zero_done", 8'h00, 8'h02);

        // asynchronous reset mid-run at 0x37
        cyc(8'h02, 8'h40);
        cyc(8'h01, 8'h00);
        for (int j = 0; j < 9; j++) cyc(8'h00, 8'h00);
        chk("pre_reset", 8'h37, 8'h01);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(8'h00, 8'h00);
        chk("after_reset", 8'h00, 8'h00);

        // randomized run against the model
        @(negedge clk);
        rst_n = 1'b0;
        ui_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cur_start = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) cur_start = ~cur_start;
            u[0]   = cur_start;
            u[1]   = ($urandom_range(0, 9) == 0);
            u[2]   = 1'($urandom_range(0, 1));
            u[3]   = ($urandom_range(0, 29) == 0);
            u[4]   = 1'($urandom_range(0, 1));
            u[7:5] = 3'($urandom_range(0, 2));
            v      = 8'($urandom_range(1, 20));
            cyc(u, v);
            model_step(u, v);
            chk($sformatf("random_c%0d", n), 8'(m_cnt), model_status());
        end
        checks++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL uio_const: got out=%02h oe=%02h exp=00/00", uio_out, uio_oe);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_um_downtimer8_reload.md
# tt_um_downtimer8_reload

8-bit programmable down-counting timer with a reload register, one-shot and periodic modes, a power-of-two prescaler and a terminal-count pulse. It counts down from a loaded value to zero, while the existing loadable up-counter counts up from zero. It uses the same TinyTapeout top-level pin frame and pin conventions, so both blocks can share a tile and a bench harness.

## Interface
- Parameters: none at top level. Core parameters: `WIDTH`, default 8, counter and reload width. `PSW`, default 7, prescaler width.
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `ui_in[0]`  in  1  `start`; a rising edge starts or restarts the timer
- `ui_in[1]`  in  1  `load`; synchronous write of `uio_in` into the reload register
- `ui_in[2]`  in  1  `sel`; 1 → `uo_out` shows the count, 0 → `uo_out` shows the status byte
- `ui_in[3]`  in  1  `stop`; level, aborts a run
- `ui_in[4]`  in  1  `mode`; 0 = one-shot, 1 = periodic
- `ui_in[7:5]`  in  3  `psel`; one tick every 2^psel cycles
- `uio_in`  in  8  reload value
- `uo_out`  out  8  count or status byte, never Z
- `uio_out`  out  8  constant 0
- `uio_oe`  out  8  constant 0, all uio pins are inputs
- `ena`  in  1  unused

## Operation
- Registers:
  - `cnt[7:0]`, `reload[7:0]`, `pre[6:0]`
  - `start_q`, the previous value of `start`
  - `state`: IDLE / RUN / DONE
  - `tc`
  - `mode_l`, `psel_l`, latched at start
- Reset value of every register is 0, so state = IDLE and `uo_out` = 0x00 for either `sel`.
- Start edge is `start & ~start_q`. All inputs are synchronous to `clk`; there is no synchronizer.
- Load: when `load` = 1, `reload` ← `uio_in` at the next edge. Load is accepted in every state.
- Start edge accepted in any state while `stop` = 0; a start edge while `stop` = 1 is ignored:
  - `cnt` ← `reload` and `pre` ← 0.
  - `mode_l`, `psel_l` are latched.
  - State goes to RUN.
  - If `load` is high in the same cycle, `cnt` ← `uio_in` (bypass) and `reload` ← `uio_in`.
  - A start edge while already in RUN restarts the timer.
- Zero reload: a start with an effective value of 0 goes straight to DONE, pulses `tc` for one cycle and never enters RUN. This holds in both modes.
- Tick: in RUN, `tick` = (`pre` == 2^psel_l − 1). `pre` increments every cycle and clears on `tick`.
- RUN, on a tick:
  - `cnt` > 1 → `cnt` − 1.
  - `cnt` == 1 and one-shot → `cnt` ← 0, `tc` ← 1, state → DONE.
  - `cnt` == 1 and periodic → `cnt` ← `reload` (current value, including any load made mid-run), `tc` ← 1, stay in RUN.
- `stop` = 1 in RUN → IDLE at the next edge; `cnt` is frozen at its current value and `tc` is not asserted.
- `tc` is a one-cycle pulse; it is cleared on the edge after it was set.
- DONE holds `cnt` = 0 until a start edge.
- Status byte: [0] busy (state == RUN), [1] done (state == DONE), [2] `tc`, [3] `mode_l`, [7:4] = 0.
- Arithmetic is unsigned 8-bit. The counter never wraps below 0 because the `cnt` == 1 rule catches it.

## Timing
- Start edge sampled at edge k: `cnt` = reload and busy = 1 after edge k.
- Divide-by-1 (`psel` = 0): `cnt` = N−j after edge k+j.
- One-shot with reload N: `cnt` = 0, `tc` = 1 and done = 1 after edge k + N·2^psel. `tc` returns to 0 one edge later.
- Periodic: `tc` pulses every N·2^psel cycles.
- Output path is combinational from registers: `uo_out` follows `sel` in the same cycle.
- `rst_n` low takes effect immediately and asynchronously, including mid-run. Operation resumes with the first edge after release.

## Structure
- A shared package/include `downtimer_pkg` holds the state encoding (IDLE = 0, RUN = 1, DONE = 2) and the status bit index constants.
- Sub-module `downtimer_core` (`WIDTH`, `PSW`) contains the FSM, counter, prescaler and reload register.
- The top `tt_um_downtimer8_reload` does pin mapping, start-edge detect and the output mux only.

## Test plan
- Assert reset mid-run with `cnt` = 0x37 → `uo_out` = 0x00 for both `sel` values immediately; status = 0x00 after release.
- Load 0x05, one-shot, `psel` = 0, start → count sequence 5,4,3,2,1,0 on consecutive cycles; `tc` high for exactly one cycle together with 0; status = 0x02 after the `tc` cycle.
- Load 0x03, periodic, `psel` = 0 → count sequence 3,2,1,3,2,1,…; `tc` high every 3rd cycle; busy stays 1.
- Load 0x02, `psel` = 2, one-shot → each value held 4 cycles; `tc` 8 cycles after start.
- Load 0x10, stop asserted at `cnt` = 0x0A → IDLE, `cnt` stays 0x0A, no `tc`. A start edge while `stop` = 1 is ignored; after `stop` is released, a start edge gives `cnt` = 0x10.
- Load and start in the same cycle with `uio_in` = 0x80 → `cnt` = 0x80. Start with reload 0 → `tc` pulse, done = 1, `cnt` = 0, busy never asserted.
